ctrl_sequencer: RTL and testbench

Microcoded control sequencer sitting directly upstream of the ALU/shifter/register datapath; it produces the 9-bit `ctrl_bus` that datapath consumes. A one-cycle `start` with a 2-bit program select runs a short fixed micro-program, emitting one control word per clock. It signals completion with a one-cycle `done` pulse, then returns to an idle word.

---
 rtl/ctrl_seq_pkg.sv | 41 ++++
 rtl/ctrl_sequencer_ucode_rom.sv | 14 +
 rtl/ctrl_sequencer.sv | 109 ++++++++++
 tb/tb_ctrl_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_seq_pkg.sv
// Shared constants, state encoding and micro-program contents for ctrl_sequencer.
package ctrl_seq_pkg;

    localparam int CTRL_W    = 9;
    localparam int ROM_W     = CTRL_W + 1;
    localparam int ROM_DEPTH = 16;
    localparam int MAX_STEPS = 4;

    localparam logic [CTRL_W-1:0] IDLE_WORD = 9'h100;

    // Datapath field positions inside a control word.
    localparam int ALU_OP_LSB  = 0;
    localparam int ALU_OP_MSB  = 2;
    localparam int MUX_SEL_BIT = 3;
    localparam int SHIFT_LSB   = 4;
    localparam int SHIFT_MSB   = 5;
    localparam int R_CTRL_BIT  = 6;
    localparam int Q_CTRL_BIT  = 7;
    localparam int IDLE_BIT    = 8;

    // ROM entry layout: bit CTRL_W is the "last word of program" flag.
    localparam int LAST_BIT = CTRL_W;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Four 4-entry program slots; unused entries hold the idle word and end the run.
    localparam logic [ROM_W-1:0] UCODE [ROM_DEPTH] = '{
        10'h2C0, 10'h300, 10'h300, 10'h300,   // op0: 0C0
        10'h200, 10'h300, 10'h300, 10'h300,   // op1: 000
        10'h001, 10'h209, 10'h300, 10'h300,   // op2: 001, 009
        10'h0C0, 10'h001, 10'h219, 10'h300    // op3: 0C0, 001, 019
    };

    function automatic logic [3:0] entry_point(input logic [1:0] op);
        return {op, 2'b00};
    endfunction

endpackage

// File: rtl/ctrl_sequencer_ucode_rom.sv
// Combinational micro-code ROM: addr -> {last, ctrl}.
module ucode_rom
    import ctrl_seq_pkg::*;
(
    input  logic [3:0]       addr,
    output logic [ROM_W-1:0] data
);

    // Pure table lookup, no state.
    always_comb begin
        data = UCODE[addr];
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Microcoded control sequencer: runs a short fixed program per start, one word per clock.
//
//  state | meaning
//  IDLE  | ctrl_bus holds IDLE_WORD; waiting for start (abort wins over start)
//  RUN   | a program word is on ctrl_bus; advance, finish on last/guard, or abort
module ctrl_sequencer
    import ctrl_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic              abort,
    output logic [CTRL_W-1:0] ctrl_bus,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] STEP_LAST = 2'(MAX_STEPS - 1);

    state_t              state, state_nxt;
    logic [3:0]          upc, upc_nxt;
    logic [3:0]          upc_inc;
    logic [1:0]          step, step_nxt;
    logic                last_q, last_nxt;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_nxt;
    logic                done_q, done_nxt;
    logic [3:0]          rom_addr;
    logic [ROM_W-1:0]    rom_data;

    // Increment wraps within the 4-entry slot so upc can never cross into another program.
    assign upc_inc = {upc[3:2], upc[1:0] + 2'd1};

    ucode_rom u_rom (
        .addr (rom_addr),
        .data (rom_data)
    );

    // State and every output-driving value are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            upc    <= 4'd0;
            step   <= 2'd0;
            last_q <= 1'b0;
            ctrl_q <= IDLE_WORD;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            upc    <= upc_nxt;
            step   <= step_nxt;
            last_q <= last_nxt;
            ctrl_q <= ctrl_nxt;
            done_q <= done_nxt;
        end
    end

    // Next-state logic; the ROM is addressed with the word that would be issued next.
    always_comb begin
        state_nxt = state;
        upc_nxt   = upc;
        step_nxt  = step;
        last_nxt  = last_q;
        ctrl_nxt  = ctrl_q;
        done_nxt  = 1'b0;
        rom_addr  = (state == IDLE) ? entry_point(op) : upc_inc;

        case (state)
            IDLE: begin
                ctrl_nxt = IDLE_WORD;
                if (start && !abort) begin
                    state_nxt = RUN;
                    upc_nxt   = entry_point(op);
                    step_nxt  = 2'd0;
                    ctrl_nxt  = rom_data[CTRL_W-1:0];
                    last_nxt  = rom_data[LAST_BIT];
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                    step_nxt  = 2'd0;
                    last_nxt  = 1'b0;
                    ctrl_nxt  = IDLE_WORD;
                end else if (last_q || (step == STEP_LAST)) begin
                    state_nxt = IDLE;
                    step_nxt  = 2'd0;
                    last_nxt  = 1'b0;
                    ctrl_nxt  = IDLE_WORD;
                    done_nxt  = 1'b1;
                end else begin
                    upc_nxt  = upc_inc;
                    step_nxt = step + 2'd1;
                    ctrl_nxt = rom_data[CTRL_W-1:0];
                    last_nxt = rom_data[LAST_BIT];
                end
            end
            default: begin
                state_nxt = IDLE;
                ctrl_nxt  = IDLE_WORD;
            end
        endcase
    end

    assign ctrl_bus = ctrl_q;
    assign busy     = (state == RUN);
    assign done     = done_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer using an expected-value queue.
module tb_ctrl_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [1:0] op;
    logic [8:0] ctrl_bus;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [8:0] ctrl;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    ctrl_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .abort    (abort),
        .ctrl_bus (ctrl_bus),
        .busy     (busy),
        .done     (done)
    );

    task automatic test_reset();
        exp_t e, got;
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; op = 2'd0;
        #3 rst_n = 1'b0;
        exp_q.push_back({9'h100, 1'b0, 1'b0});
        #1;
        e = exp_q.pop_front(); got = {ctrl_bus, busy, done};
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_async: got %h/%b/%b want %h/%b/%b", got.ctrl, got.busy, got.done, e.ctrl, e.busy, e.done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_op1();
        exp_t e, got;
        start = 1'b1; op = 2'd1;
        exp_q.push_back({9'h000, 1'b1, 1'b0});
        exp_q.push_back({9'h100, 1'b0, 1'b1});
        exp_q.push_back({9'h100, 1'b0, 1'b0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            e = exp_q.pop_front(); got = {ctrl_bus, busy, done};
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL op1[%0d]: got %h/%b/%b want %h/%b/%b", i, got.ctrl, got.busy, got.done, e.ctrl, e.busy, e.done);
            end
        end
    endtask

    task automatic test_op3();
        exp_t e, got;
        start = 1'b1; op = 2'd3;
        exp_q.push_back({9'h0C0, 1'b1, 1'b0});
        exp_q.push_back({9'h001, 1'b1, 1'b0});
        exp_q.push_back({9'h019, 1'b1, 1'b0});
        exp_q.push_back({9'h100, 1'b0, 1'b1});
        exp_q.push_back({9'h100, 1'b0, 1'b0});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
            op    = 2'(i);
            e = exp_q.pop_front(); got = {ctrl_bus, busy, done};
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL op3[%0d]: got %h/%b/%b want %h/%b/%b", i, got.ctrl, got.busy, got.done, e.ctrl, e.busy, e.done);
            end
        end
    endtask

    task automatic test_abort();
        exp_t e, got;
        start = 1'b1; op = 2'd2;
        exp_q.push_back({9'h001, 1'b1, 1'b0});
        exp_q.push_back({9'h100, 1'b0, 1'b0});
        exp_q.push_back({9'h100, 1'b0, 1'b0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            abort = (i == 0);
            e = exp_q.pop_front(); got = {ctrl_bus, busy, done};
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL abort_run[%0d]: got %h/%b/%b want %h/%b/%b", i, got.ctrl, got.busy, got.done, e.ctrl, e.busy, e.done);
            end
        end
        start = 1'b1; abort = 1'b1; op = 2'd3;
        exp_q.push_back({9'h100, 1'b0, 1'b0});
        exp_q.push_back({9'h100, 1'b0, 1'b0});
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (i == 1) begin start = 1'b0; abort = 1'b0; end
            e = exp_q.pop_front(); got = {ctrl_bus, busy, done};
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL start_abort_idle[%0d]: got %h/%b/%b want %h/%b/%b", i, got.ctrl, got.busy, got.done, e.ctrl, e.busy, e.done);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, got;
        start = 1'b1; op = 2'd2;
        for (int r = 0; r < 3; r++) begin
            exp_q.push_back({9'h001, 1'b1, 1'b0});
            exp_q.push_back({9'h009, 1'b1, 1'b0});
            exp_q.push_back({9'h100, 1'b0, 1'b1});
        end
        exp_q.push_back({9'h100, 1'b0, 1'b0});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 6) start = 1'b0;
            e = exp_q.pop_front(); got = {ctrl_bus, busy, done};
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %h/%b/%b want %h/%b/%b", i, got.ctrl, got.busy, got.done, e.ctrl, e.busy, e.done);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        exp_t e, got;
        start = 1'b1; op = 2'd3;
        exp_q.push_back({9'h0C0, 1'b1, 1'b0});
        exp_q.push_back({9'h001, 1'b1, 1'b0});
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start = 1'b0;
            e = exp_q.pop_front(); got = {ctrl_bus, busy, done};
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL pre_reset[%0d]: got %h/%b/%b want %h/%b/%b", i, got.ctrl, got.busy, got.done, e.ctrl, e.busy, e.done);
            end
        end
        #1 rst_n = 1'b0;
        exp_q.push_back({9'h100, 1'b0, 1'b0});
        #1;
        e = exp_q.pop_front(); got = {ctrl_bus, busy, done};
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_mid_run: got %h/%b/%b want %h/%b/%b", got.ctrl, got.busy, got.done, e.ctrl, e.busy, e.done);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1; op = 2'd0;
        exp_q.push_back({9'h0C0, 1'b1, 1'b0});
        exp_q.push_back({9'h100, 1'b0, 1'b1});
        exp_q.push_back({9'h100, 1'b0, 1'b0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            e = exp_q.pop_front(); got = {ctrl_bus, busy, done};
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL post_reset_op0[%0d]: got %h/%b/%b want %h/%b/%b", i, got.ctrl, got.busy, got.done, e.ctrl, e.busy, e.done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_op1();
        test_op3();
        test_abort();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
